// File: rtl/sweep_seq_pkg.sv
// Shared types and config-field layout for the sweep sequencer.
// Imported by the interface, the trigger lanes and the top.
package sweep_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int CFG_BITS  = 3;
    localparam int CFG_INV   = 0;
    localparam int CFG_FIRST = 1;
    localparam int CFG_REST  = 2;

endpackage

// File: rtl/sweep_sequencer_if.sv
// Config/control and trigger bundle between register block and sequencer.
// master = register side, slave = sequencer.
interface sweep_sequencer_if
    import sweep_seq_pkg::*;
#(
    parameter int NUM_GEN = 2,
    parameter int CNT_W   = 32,
    parameter int TRIG_W  = 24,
    parameter int IDX_W   = 16
);
    logic                        start;
    logic                        abort;
    logic [CNT_W-1:0]            dead_time;
    logic [CNT_W-1:0]            point_time;
    logic [TRIG_W-1:0]           trig_time;
    logic [IDX_W-1:0]            num_points;
    logic [CFG_BITS*NUM_GEN-1:0] gen_cfg;

    logic [NUM_GEN-1:0]          gen_trigger;
    logic                        accumulator_trigger;
    logic                        point_done;
    logic [IDX_W-1:0]            point_index;
    logic                        busy;
    logic                        sweep_done;

    modport master (
        output start, abort, dead_time, point_time,
        output trig_time, num_points, gen_cfg,
        input  gen_trigger, accumulator_trigger, point_done,
        input  point_index, busy, sweep_done
    );

    modport slave (
        input  start, abort, dead_time, point_time,
        input  trig_time, num_points, gen_cfg,
        output gen_trigger, accumulator_trigger, point_done,
        output point_index, busy, sweep_done
    );

endinterface

// File: rtl/seq_trig_lane.sv
// One generator trigger channel: latched invert/first/rest policy
// applied to the shared gen_active window.
module seq_trig_lane
    import sweep_seq_pkg::*;
(
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                load_i,
    input  logic [CFG_BITS-1:0] cfg_i,
    input  logic                gen_active_i,
    input  logic                first_i,
    output logic                trig_o
);

    logic [CFG_BITS-1:0] cfg_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cfg_q <= '0;
        end else if (load_i) begin
            cfg_q <= cfg_i;
        end
    end

    assign trig_o = cfg_q[CFG_INV] ^
        (gen_active_i & (first_i ? cfg_q[CFG_FIRST] : cfg_q[CFG_REST]));

endmodule

// File: rtl/sweep_sequencer.sv
// Multi-channel point sweep sequencer: point timing, accumulator gate,
// per-point strobes and sweep completion.
module sweep_sequencer
    import sweep_seq_pkg::*;
#(
    parameter int NUM_GEN = 2,
    parameter int CNT_W   = 32,
    parameter int TRIG_W  = 24,
    parameter int IDX_W   = 16
) (
    input  logic             aclk,
    input  logic             rst,
    sweep_sequencer_if.slave bus
);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] dt_q, dt_d;
    logic [CNT_W-1:0] pt_q, pt_d;
    logic [CNT_W-1:0] tt_q, tt_d;
    logic [IDX_W-1:0] np_q, np_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             first_q, first_d;
    logic             first_r_q, first_r_d;
    logic             act_q, act_d;
    logic             acc_q, acc_d;
    logic             pd_q, pd_d;
    logic             load;
    logic             pt_hit;
    logic             last_pt;
    logic [NUM_GEN-1:0] trig;

    assign pt_hit  = (cnt_q == pt_q);
    assign last_pt = (np_q != '0) && (idx_q == np_q - IDX_W'(1));

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        dt_d      = dt_q;
        pt_d      = pt_q;
        tt_d      = tt_q;
        np_d      = np_q;
        idx_d     = idx_q;
        first_d   = first_q;
        first_r_d = first_r_q;
        act_d     = act_q;
        acc_d     = acc_q;
        pd_d      = pd_q;
        load      = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.start && !bus.abort) begin
                    load    = 1'b1;
                    dt_d    = bus.dead_time;
                    pt_d    = bus.point_time;
                    tt_d    = CNT_W'(bus.trig_time);
                    np_d    = bus.num_points;
                    cnt_d   = '0;
                    idx_d   = '0;
                    first_d = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (bus.abort) begin
                    act_d   = 1'b0;
                    acc_d   = 1'b0;
                    pd_d    = 1'b0;
                    state_d = IDLE;
                end else begin
                    act_d     = (cnt_q < tt_q);
                    acc_d     = (cnt_q > dt_q);
                    pd_d      = pt_hit;
                    first_r_d = first_q;
                    if (pt_hit) begin
                        cnt_d   = '0;
                        first_d = 1'b0;
                        idx_d   = idx_q + IDX_W'(1);
                        if (last_pt) state_d = DONE;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            DONE: begin
                // last point's registered outputs were shown this cycle
                act_d   = 1'b0;
                acc_d   = 1'b0;
                pd_d    = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge aclk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            dt_q      <= '0;
            pt_q      <= '0;
            tt_q      <= '0;
            np_q      <= '0;
            idx_q     <= '0;
            first_q   <= 1'b0;
            first_r_q <= 1'b0;
            act_q     <= 1'b0;
            acc_q     <= 1'b0;
            pd_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            dt_q      <= dt_d;
            pt_q      <= pt_d;
            tt_q      <= tt_d;
            np_q      <= np_d;
            idx_q     <= idx_d;
            first_q   <= first_d;
            first_r_q <= first_r_d;
            act_q     <= act_d;
            acc_q     <= acc_d;
            pd_q      <= pd_d;
        end
    end

    for (genvar g = 0; g < NUM_GEN; g++) begin : g_lane
        seq_trig_lane u_lane (
            .clk_i        (aclk),
            .rst_ni       (rst),
            .load_i       (load),
            .cfg_i        (bus.gen_cfg[g*CFG_BITS +: CFG_BITS]),
            .gen_active_i (act_q),
            .first_i      (first_r_q),
            .trig_o       (trig[g])
        );
    end

    assign bus.gen_trigger         = trig;
    assign bus.accumulator_trigger = acc_q;
    assign bus.point_done          = pd_q;
    assign bus.point_index         = idx_q;
    assign bus.busy                = (state_q != IDLE);
    assign bus.sweep_done          = (state_q == DONE);

endmodule

// File: tb/tb_sweep_sequencer.sv
// Scoreboard bench for sweep_sequencer: timeline model of each sweep
// predicts every output cycle; a negedge monitor compares.
module tb_sweep_sequencer;

    localparam int NG = 2;
    localparam int CW = 32;
    localparam int TW = 24;
    localparam int IW = 16;

    logic aclk = 1'b0;
    logic rst  = 1'b0;
    always #5 aclk = ~aclk;

    sweep_sequencer_if #(.NUM_GEN(NG), .CNT_W(CW), .TRIG_W(TW), .IDX_W(IW)) bus();

    sweep_sequencer #(.NUM_GEN(NG), .CNT_W(CW), .TRIG_W(TW), .IDX_W(IW)) dut (
        .aclk (aclk),
        .rst  (rst),
        .bus  (bus)
    );

    typedef struct packed {
        logic [NG-1:0] gen;
        logic          acc;
        logic          pd;
        logic          busy;
        logic          sd;
        logic [IW-1:0] idx;
        logic          ck_idx;
    } exp_t;

    exp_t q[$];
    int total = 0;
    int bad   = 0;

    // model: sweep position is just "cycles since start"
    bit            m_busy = 0;
    longint        m_k    = 0;
    longint        m_pt, m_dt, m_tt, m_np;
    logic [3*NG-1:0] m_cfg = '0;

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s @%0t: got %h want %h", nm, $time, act, exp);
        end
    endtask

    function automatic exp_t model_out();
        exp_t   e;
        longint per, c, p, cn;
        bit     ga, fp;
        per = m_pt + 1;
        ga = 0;
        fp = 0;
        e = '0;
        e.busy = m_busy;
        e.ck_idx = m_busy;
        if (m_busy && m_k >= 2) begin
            c  = m_k - 2;
            p  = c / per;
            cn = c % per;
            ga = (cn < m_tt);
            e.acc = (cn > m_dt);
            e.pd  = (cn == m_pt);
            fp = (p == 0);
        end
        if (m_busy) begin
            e.idx = IW'((m_k - 1) / per);
            e.sd  = (m_np != 0) && (m_k == m_np * per + 1);
        end
        for (int i = 0; i < NG; i++) begin
            e.gen[i] = m_cfg[3*i] ^
                (ga & (fp ? m_cfg[3*i+1] : m_cfg[3*i+2]));
        end
        return e;
    endfunction

    task automatic model_edge();
        if (!m_busy) begin
            if (bus.start && !bus.abort) begin
                m_busy = 1;
                m_k    = 1;
                m_pt   = longint'(bus.point_time);
                m_dt   = longint'(bus.dead_time);
                m_tt   = longint'(bus.trig_time);
                m_np   = longint'(bus.num_points);
                m_cfg  = bus.gen_cfg;
            end
        end else if (bus.abort) begin
            m_busy = 0;
        end else begin
            m_k++;
            if (m_np != 0 && m_k > m_np * (m_pt + 1) + 1) m_busy = 0;
        end
    endtask

    task automatic step(bit s, bit a);
        bus.start = s;
        bus.abort = a;
        @(posedge aclk);
        model_edge();
        #1;
        q.push_back(model_out());
        bus.start = 1'b0;
        bus.abort = 1'b0;
    endtask

    task automatic set_cfg(int pt, int dt, int tt, int np, int gc);
        bus.point_time = CW'(pt);
        bus.dead_time  = CW'(dt);
        bus.trig_time  = TW'(tt);
        bus.num_points = IW'(np);
        bus.gen_cfg    = (3*NG)'(gc);
    endtask

    task automatic idle_steps(int n);
        for (int i = 0; i < n; i++) step(0, 0);
    endtask

    task automatic run_out(int budget);
        int n;
        n = 0;
        while (m_busy && n < budget) begin
            step(0, 0);
            n++;
        end
        total++;
        if (m_busy) begin
            bad++;
            $display("FAIL sweep_end: still busy after %0d cycles", budget);
        end
    endtask

    task automatic check_reset_state(string nm);
        chk({nm, "_outs"},
            {bus.busy, bus.sweep_done, bus.point_done,
             bus.accumulator_trigger, bus.gen_trigger}, 64'd0);
        chk({nm, "_idx"}, bus.point_index, 64'd0);
    endtask

    always @(negedge aclk) begin
        exp_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            chk("outs",
                {bus.busy, bus.sweep_done, bus.point_done,
                 bus.accumulator_trigger, bus.gen_trigger},
                {e.busy, e.sd, e.pd, e.acc, e.gen});
            if (e.ck_idx) chk("idx", bus.point_index, e.idx);
        end
    end

    initial begin
        int pt, np, n;
        bus.start = 1'b0;
        bus.abort = 1'b0;
        set_cfg(0, 0, 0, 0, 0);

        repeat (3) @(posedge aclk);
        #2;
        check_reset_state("por");
        rst = 1'b1;
        idle_steps(2);

        // basic two-channel sweep
        set_cfg(9, 4, 3, 3, 6'b010_110);
        step(1, 0);
        run_out(40);
        idle_steps(3);

        // inverted rest-only channel
        set_cfg(5, 1, 2, 2, 6'b000_101);
        step(1, 0);
        run_out(20);
        idle_steps(3);

        // continuous, then abort
        set_cfg(4, 2, 2, 0, 6'b110_110);
        step(1, 0);
        idle_steps(23);
        step(0, 1);
        idle_steps(3);

        // start+abort together in IDLE
        set_cfg(3, 0, 1, 2, 6'b011_011);
        step(1, 1);
        idle_steps(2);

        // start while running with another point_time
        step(1, 0);
        idle_steps(3);
        bus.point_time = CW'(7);
        step(1, 0);
        run_out(20);
        idle_steps(2);

        // 1-cycle points
        set_cfg(0, 0, 1, 4, 6'b110_110);
        step(1, 0);
        run_out(10);
        idle_steps(2);

        // async reset mid-run, then fresh start at index 0
        set_cfg(3, 1, 2, 0, 6'b111_101);
        step(1, 0);
        idle_steps(9);
        @(negedge aclk);
        #2;
        rst = 1'b0;
        #1;
        check_reset_state("arst");
        m_busy = 0;
        m_cfg  = '0;
        @(posedge aclk);
        #2;
        rst = 1'b1;
        idle_steps(1);
        step(1, 0);
        idle_steps(8);
        step(0, 1);
        idle_steps(2);

        // index wrap in continuous mode
        set_cfg(0, 0, 1, 0, 6'b010_100);
        step(1, 0);
        idle_steps(65540);
        step(0, 1);
        idle_steps(2);

        // randomized sweeps with ignored starts and config churn
        repeat (30) begin
            pt = $urandom_range(0, 6);
            np = $urandom_range(0, 4);
            set_cfg(pt, $urandom_range(0, 7), $urandom_range(0, 8),
                    np, $urandom_range(0, 63));
            step(1, $urandom_range(0, 9) == 0);
            n = (np == 0) ? 30 : np * (pt + 1) + 3;
            for (int i = 0; i < n; i++) begin
                if ($urandom_range(0, 3) == 0)
                    bus.point_time = CW'($urandom_range(0, 6));
                step($urandom_range(0, 7) == 0,
                     ($urandom_range(0, 39) == 0) ||
                     (np == 0 && i == n - 1));
            end
            idle_steps(2);
        end

        @(negedge aclk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
